// File: rtl/logic_eval_sequencer.sv
// Truth-table sweep sequencer: walks every input vector of a small combinational
// unit, waits SETTLE cycles per vector, records its output and scores it against a mask.
module logic_eval_sequencer #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [(1<<N_IN)-1:0]   expected,
  output logic [N_IN-1:0]        dut_in,
  input  logic                   dut_y,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [(1<<N_IN)-1:0]   truth,
  output logic [N_IN:0]          err_count,
  output logic                   first_err_valid,
  output logic [N_IN-1:0]        first_err_idx
);

  localparam int W     = 1 << N_IN;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
  localparam logic [N_IN-1:0]  IDX_LAST = N_IN'(W - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t state_r, state_s;

  logic [W-1:0]      expected_q_r, expected_q_s;
  logic [N_IN-1:0]   idx_r, idx_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [N_IN-1:0]   dut_in_r, dut_in_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              pass_r, pass_s;
  logic [W-1:0]      truth_r, truth_s;
  logic [N_IN:0]     err_count_r, err_count_s;
  logic              first_err_valid_r, first_err_valid_s;
  logic [N_IN-1:0]   first_err_idx_r, first_err_idx_s;
  logic              mismatch_s;
  logic              accept_start_s;

  function automatic logic vec_mismatch(input logic [W-1:0] exp_tt,
                                        input logic [N_IN-1:0] vec,
                                        input logic y);
    return y ^ exp_tt[vec];
  endfunction

  assign mismatch_s     = vec_mismatch(expected_q_r, idx_r, dut_y);
  assign accept_start_s = start & ~abort;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; abort wins over everything except a completing DONE
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_start_s) begin
          state_s = ST_SETTLE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_s = ST_IDLE;
        end else if (cnt_r == '0) begin
          state_s = ST_SAMPLE;
        end else begin
          state_s = ST_SETTLE;
        end
      end
      ST_SAMPLE: begin
        if (abort) begin
          state_s = ST_IDLE;
        end else if (idx_r == IDX_LAST) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_SETTLE;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Datapath and output next values, all registered below
  always_comb begin
    expected_q_s      = expected_q_r;
    idx_s             = idx_r;
    cnt_s             = cnt_r;
    dut_in_s          = dut_in_r;
    pass_s            = pass_r;
    truth_s           = truth_r;
    err_count_s       = err_count_r;
    first_err_valid_s = first_err_valid_r;
    first_err_idx_s   = first_err_idx_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_start_s) begin
          expected_q_s      = expected;
          truth_s           = '0;
          err_count_s       = '0;
          first_err_valid_s = 1'b0;
          first_err_idx_s   = '0;
          pass_s            = 1'b0;
          idx_s             = '0;
          dut_in_s          = '0;
          cnt_s             = CNT_LOAD;
        end else begin
          dut_in_s = dut_in_r;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          pass_s   = 1'b0;
          dut_in_s = '0;
          idx_s    = '0;
        end else if (cnt_r != '0) begin
          cnt_s = cnt_r - CNT_W'(1);
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_SAMPLE: begin
        if (abort) begin
          pass_s   = 1'b0;
          dut_in_s = '0;
          idx_s    = '0;
        end else begin
          truth_s[idx_r] = dut_y;
          if (mismatch_s) begin
            err_count_s = err_count_r + (N_IN+1)'(1);
            if (!first_err_valid_r) begin
              first_err_valid_s = 1'b1;
              first_err_idx_s   = idx_r;
            end else begin
              first_err_idx_s = first_err_idx_r;
            end
          end else begin
            err_count_s = err_count_r;
          end
          // The last vector leaves dut_in parked at W-1 until the next sweep
          if (idx_r != IDX_LAST) begin
            idx_s    = idx_r + N_IN'(1);
            dut_in_s = idx_r + N_IN'(1);
            cnt_s    = CNT_LOAD;
          end else begin
            idx_s = idx_r;
          end
        end
      end
      ST_DONE: begin
        pass_s = (err_count_r == '0);
      end
      default: begin
        pass_s = 1'b0;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
    done_s = (state_s == ST_DONE);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      expected_q_r      <= '0;
      idx_r             <= '0;
      cnt_r             <= '0;
      dut_in_r          <= '0;
      busy_r            <= 1'b0;
      done_r            <= 1'b0;
      pass_r            <= 1'b0;
      truth_r           <= '0;
      err_count_r       <= '0;
      first_err_valid_r <= 1'b0;
      first_err_idx_r   <= '0;
    end else begin
      expected_q_r      <= expected_q_s;
      idx_r             <= idx_s;
      cnt_r             <= cnt_s;
      dut_in_r          <= dut_in_s;
      busy_r            <= busy_s;
      done_r            <= done_s;
      pass_r            <= pass_s;
      truth_r           <= truth_s;
      err_count_r       <= err_count_s;
      first_err_valid_r <= first_err_valid_s;
      first_err_idx_r   <= first_err_idx_s;
    end
  end

  assign dut_in          = dut_in_r;
  assign busy            = busy_r;
  assign done            = done_r;
  assign pass            = pass_r;
  assign truth           = truth_r;
  assign err_count       = err_count_r;
  assign first_err_valid = first_err_valid_r;
  assign first_err_idx   = first_err_idx_r;

endmodule
